// File: rtl/hazard_control_unit_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_control_unit.
// master: datapath side, which drives the stage status and receives the stall/flush controls.
// slave:  the hazard unit, which receives the status and drives the controls and counters.
//   E_op, E_dstM, D_srcA, D_srcB, D_uses_hilo, E_md_start, E_mispredict, M_mem_busy: status
//   F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, W_bubble: pipeline controls
//   md_busy: mul/div unit busy; stall_cnt, flush_cnt: saturating performance counters
interface hazard_control_unit_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned OP_W  = 6,
  parameter int unsigned CNT_W = 32
);
  logic [OP_W-1:0]  E_op;
  logic [REG_W-1:0] E_dstM;
  logic [REG_W-1:0] D_srcA;
  logic [REG_W-1:0] D_srcB;
  logic             D_uses_hilo;
  logic             E_md_start;
  logic             E_mispredict;
  logic             M_mem_busy;
  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_stall;
  logic             E_bubble;
  logic             M_stall;
  logic             W_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output E_op, E_dstM, D_srcA, D_srcB, D_uses_hilo, E_md_start, E_mispredict, M_mem_busy,
    input  F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, W_bubble, md_busy,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  E_op, E_dstM, D_srcA, D_srcB, D_uses_hilo, E_md_start, E_mispredict, M_mem_busy,
    output F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, W_bubble, md_busy,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Central stall/flush controller for a 5-stage F/D/E/M/W pipeline.
// Resolves memory wait states, mispredict flushes, load-use hazards (with a configurable
// bubble count) and the multi-cycle mul/div interlock, in that priority order, and keeps
// saturating counts of stall cycles and flushes.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; all pipeline controls read 0 while it is high
//   hz   hazard_control_unit_if.slave bundle (stage status in, controls/counters out)
module hazard_control_unit #(
  parameter int unsigned     REG_W  = 5,
  parameter int unsigned     OP_W   = 6,
  parameter logic [OP_W-1:0] OP_LW  = OP_W'(6'h23),
  parameter int unsigned     LU_CYC = 1,
  parameter int unsigned     MD_LAT = 32,
  parameter int unsigned     CNT_W  = 32
) (
  input logic                  clk,
  input logic                  rst,
  hazard_control_unit_if.slave hz
);

  localparam int unsigned LuW = (LU_CYC > 1) ? $clog2(LU_CYC) : 1;
  localparam int unsigned MdW = $clog2(MD_LAT);

  typedef enum logic {LuIdle, LuWait} lu_state_e;
  typedef enum logic {MdIdle, MdBusy} md_state_e;

  lu_state_e        lu_state_q;
  logic [LuW-1:0]   lu_left_q;
  md_state_e        md_state_q;
  logic [MdW-1:0]   md_left_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic lu_hit, md_busy;
  logic mem_term, flush_term, lu_term, md_term;
  logic f_stall;

  // Precise match only: a zero destination never hazards.
  assign lu_hit = (hz.E_op == OP_LW) && (hz.E_dstM != REG_W'(0)) &&
                  ((hz.E_dstM == hz.D_srcA) || (hz.E_dstM == hz.D_srcB));

  assign md_busy    = (md_state_q == MdBusy);
  assign mem_term   = hz.M_mem_busy;
  assign flush_term = !mem_term && hz.E_mispredict;
  assign lu_term    = !mem_term && !flush_term && (lu_hit || (lu_state_q == LuWait));
  assign md_term    = !mem_term && !flush_term && md_busy && (hz.D_uses_hilo || hz.E_md_start);

  // Controls are combinational so a load-use hit stalls in the same cycle; gating with rst
  // makes them drop immediately on an asynchronous reset.
  always_comb begin
    f_stall     = 1'b0;
    hz.D_stall  = 1'b0;
    hz.D_bubble = 1'b0;
    hz.E_stall  = 1'b0;
    hz.E_bubble = 1'b0;
    hz.M_stall  = 1'b0;
    hz.W_bubble = 1'b0;
    if (!rst) begin
      f_stall     = mem_term || lu_term || md_term;
      hz.D_stall  = mem_term || lu_term || md_term;
      hz.E_stall  = mem_term;
      hz.M_stall  = mem_term;
      hz.W_bubble = mem_term;
      hz.D_bubble = flush_term;
      hz.E_bubble = flush_term || lu_term || md_term;
    end
  end

  assign hz.F_stall   = f_stall;
  assign hz.md_busy   = md_busy;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

  // Load-use FSM: holds through memory waits, aborts on a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_state_q <= LuIdle;
      lu_left_q  <= '0;
    end else if (!mem_term) begin
      if (flush_term) begin
        lu_state_q <= LuIdle;
        lu_left_q  <= '0;
      end else begin
        unique case (lu_state_q)
          LuIdle: begin
            if (lu_hit && (LU_CYC > 1)) begin
              lu_state_q <= LuWait;
              lu_left_q  <= LuW'(LU_CYC - 1);
            end
          end
          LuWait: begin
            lu_left_q <= lu_left_q - LuW'(1);
            if (lu_left_q == LuW'(1)) lu_state_q <= LuIdle;
          end
          default: lu_state_q <= LuIdle;
        endcase
      end
    end
  end

  // Mul/div FSM: counts regardless of stalls; a start while busy is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_state_q <= MdIdle;
      md_left_q  <= '0;
    end else begin
      unique case (md_state_q)
        MdIdle: begin
          if (hz.E_md_start) begin
            md_state_q <= MdBusy;
            md_left_q  <= MdW'(MD_LAT - 1);
          end
        end
        MdBusy: begin
          md_left_q <= md_left_q - MdW'(1);
          if (md_left_q == MdW'(1)) md_state_q <= MdIdle;
        end
        default: md_state_q <= MdIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (f_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_term && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

endmodule
